riscv_mult_iter: RTL and testbench

Parametrised iterative multiplier for the RI5CY EX stage: computes WIDTH×WIDTH products one SLICE×SLICE partial product per cycle. Produces the low word (MUL, MAC) or the high word (MULH/MULHSU/MULHU) of the 2·WIDTH-bit product. It uses a valid/ready handshake on both sides and skips partial products that cannot affect a low-word result. It generalises the fixed 32-bit, 16-bit-slice MULH sequencer to arbitrary width and slice count, for the 64-bit core variant and area-reduced cluster cores.

---
 rtl/riscv_mult_pkg.sv | 23 ++
 rtl/riscv_mult_slice.sv | 20 ++
 rtl/riscv_mult_iter.sv | 163 ++++++++++++++++
 tb/tb_riscv_mult_iter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mult_pkg.sv
// Shared types and helpers for the iterative RI5CY multiplier.
// Operation and FSM state encodings, plus the partial-product count per operation.
package riscv_mult_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_MAC = 2'b01,
    MUL_HI  = 2'b10
  } mult_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mult_state_e;

  // Low-word results only need pairs with i+j < nslice.
  function automatic int mult_pairs(mult_op_e op, int nslice);
    if (op == MUL_HI) return nslice * nslice;
    return nslice * (nslice + 1) / 2;
  endfunction

endpackage

// File: rtl/riscv_mult_slice.sv
// One signed (SLICE+1)x(SLICE+1) partial product; purely combinational, DSP-mappable.
module riscv_mult_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE:0]     a_i,
  input  logic [SLICE:0]     b_i,
  output logic [2*SLICE+1:0] p_o
);

  localparam int PW = 2 * SLICE + 2;

  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;

  // Sign-extending to the full product width makes the modular product the signed one.
  assign a_x = {{(PW-SLICE-1){a_i[SLICE]}}, a_i};
  assign b_x = {{(PW-SLICE-1){b_i[SLICE]}}, b_i};
  assign p_o = a_x * b_x;

endmodule

// File: rtl/riscv_mult_iter.sv
// Iterative WIDTHxWIDTH multiplier: one SLICExSLICE partial product per cycle.
// Handshake: a request transfers when valid_i && ready_o, a result when valid_o && ready_i; flush_i overrides both.
module riscv_mult_iter
  import riscv_mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [1:0]       signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] op_c_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int AW     = 2 * WIDTH + 2;
  localparam int PW     = 2 * SLICE + 2;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE) != 0 || SLICE < 2) begin : g_bad_params
    $error("riscv_mult_iter: WIDTH must be a multiple of SLICE and SLICE must be >= 2");
  end

  mult_state_e      state_q, state_d;
  mult_op_e         op_q, op_d;
  logic             sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;

  mult_op_e         op_dec;
  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   a_ext, b_ext;
  logic [PW-1:0]    pp;
  logic [AW-1:0]    pp_sh, acc_sum;
  logic [IW:0]      ij_sum;
  logic             row_end, last_pair;

  // Encoding 2'b11 aliases MUL_LO; signed_i=2'b10 decays to unsigned x unsigned.
  assign op_dec = (op_i == 2'b11) ? MUL_LO : mult_op_e'(op_i);

  assign a_sl  = a_q[32'(i_q) * SLICE +: SLICE];
  assign b_sl  = b_q[32'(j_q) * SLICE +: SLICE];
  assign a_ext = {sgn_a_q && (i_q == IW'(NSLICE - 1)) && a_sl[SLICE-1], a_sl};
  assign b_ext = {sgn_b_q && (j_q == IW'(NSLICE - 1)) && b_sl[SLICE-1], b_sl};

  riscv_mult_slice #(.SLICE(SLICE)) u_slice (
    .a_i (a_ext),
    .b_i (b_ext),
    .p_o (pp)
  );

  assign pp_sh   = {{(AW-PW){pp[PW-1]}}, pp} << (SLICE * (32'(i_q) + 32'(j_q)));
  assign acc_sum = acc_q + pp_sh;

  // Low-word ops end each row at the anti-diagonal, so the skipped pairs cost no cycles.
  assign ij_sum    = {1'b0, i_q} + {1'b0, j_q};
  assign row_end   = (op_q == MUL_HI) ? (i_q == IW'(NSLICE - 1))
                                      : (ij_sum == (IW+1)'(NSLICE - 1));
  assign last_pair = row_end && (j_q == IW'(NSLICE - 1));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sgn_a_d  = sgn_a_q;
    sgn_b_d  = sgn_b_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    i_d      = i_q;
    j_d      = j_q;
    valid_d  = valid_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          op_d    = op_dec;
          sgn_a_d = signed_i[0];
          sgn_b_d = &signed_i;
          a_d     = op_a_i;
          b_d     = op_b_i;
          acc_d   = (op_dec == MUL_MAC) ? {{(AW-WIDTH){op_c_i[WIDTH-1]}}, op_c_i} : '0;
          i_d     = '0;
          j_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        if (last_pair) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          result_d = (op_q == MUL_HI) ? acc_sum[2*WIDTH-1:WIDTH] : acc_sum[WIDTH-1:0];
        end else if (row_end) begin
          i_d = '0;
          j_d = j_q + IW'(1);
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      acc_d   = '0;
      i_d     = '0;
      j_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= MUL_LO;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sgn_a_q  <= sgn_a_d;
      sgn_b_q  <= sgn_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      j_q      <= j_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q != IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_riscv_mult_iter.sv
// Bench for riscv_mult_iter: a 32/16 and a 64/16 instance share clock, reset and operand buses.
module tb_riscv_mult_iter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  vld, flush, rdy_in;
  logic [1:0]  rdy, vo, bsy;
  logic [1:0]  op, sg;
  logic [63:0] op_a, op_b, op_c;
  logic [31:0] res32;
  logic [63:0] res64;

  logic [63:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  riscv_mult_iter #(.WIDTH(32), .SLICE(16)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .valid_i(vld[0]), .ready_o(rdy[0]), .op_i(op), .signed_i(sg),
    .op_a_i(op_a[31:0]), .op_b_i(op_b[31:0]), .op_c_i(op_c[31:0]), .flush_i(flush[0]),
    .valid_o(vo[0]), .ready_i(rdy_in[0]), .result_o(res32), .busy_o(bsy[0])
  );

  riscv_mult_iter #(.WIDTH(64), .SLICE(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .valid_i(vld[1]), .ready_o(rdy[1]), .op_i(op), .signed_i(sg),
    .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c), .flush_i(flush[1]),
    .valid_o(vo[1]), .ready_i(rdy_in[1]), .result_o(res64), .busy_o(bsy[1])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] res_of(input int sel);
    return (sel == 0) ? {32'b0, res32} : res64;
  endfunction

  // Golden model: exact product of the interpreted operands, widened to 130 bits.
  function automatic logic [63:0] model(input int w, input logic [1:0] op_v, input logic [1:0] sg_v,
                                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    logic [129:0] ax, bx, cx, p, mask;
    mask = (130'(1) << w) - 130'(1);
    ax = 130'(a) & mask;
    bx = 130'(b) & mask;
    cx = 130'(c) & mask;
    if (sg_v[0] && a[w-1]) ax = ax - (130'(1) << w);
    if (sg_v == 2'b11 && b[w-1]) bx = bx - (130'(1) << w);
    if (c[w-1]) cx = cx - (130'(1) << w);
    p = ax * bx;
    if (op_v == 2'b01) p = p + cx;
    if (op_v == 2'b10) return 64'((p >> w) & mask);
    return 64'(p & mask);
  endfunction

  task automatic drive_req(input int sel, input logic [1:0] op_v, input logic [1:0] sg_v,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    op = op_v; sg = sg_v; op_a = a; op_b = b; op_c = c;
    vld[sel] = 1'b1;
    @(posedge clk); #1;
    vld[sel] = 1'b0;
    // Operands must have been captured at accept; scramble them afterwards.
    op   = 2'($urandom_range(0, 3));
    sg   = 2'($urandom_range(0, 3));
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    op_c = {$urandom, $urandom};
  endtask

  task automatic run_op(input string tag, input int sel, input logic [1:0] op_v, input logic [1:0] sg_v,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [63:0] expv, input int stall);
    int n, p, cyc;
    logic got, rdy_seen;
    logic [63:0] held;
    n = (sel == 0) ? 2 : 4;
    p = (op_v == 2'b10) ? n * n : n * (n + 1) / 2;
    check_val({tag, "/ready_idle"}, 64'(rdy[sel]), 64'd1);
    drive_req(sel, op_v, sg_v, a, b, c);
    exp_q.push_back(expv);
    check_val({tag, "/busy"}, 64'(bsy[sel]), 64'd1);
    got = 1'b0; cyc = 0; rdy_seen = 1'b0;
    while (!got && cyc < 100) begin
      rdy_seen = rdy_seen | rdy[sel];
      @(posedge clk); #1;
      cyc++;
      got = vo[sel];
    end
    if (!got) begin
      check_val({tag, "/timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_front());
      flush[sel] = 1'b1;
      @(posedge clk); #1;
      flush[sel] = 1'b0;
      return;
    end
    check_val({tag, "/ready_calc"}, 64'(rdy_seen), 64'd0);
    check_val({tag, "/latency"}, 64'(cyc), 64'(p));
    check_val({tag, "/result"}, res_of(sel), exp_q.pop_front());
    held = res_of(sel);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check_val({tag, "/stall_result"}, res_of(sel), held);
      check_val({tag, "/stall_valid"}, 64'(vo[sel]), 64'd1);
      check_val({tag, "/stall_ready"}, 64'(rdy[sel]), 64'd0);
    end
    rdy_in[sel] = 1'b1;
    @(posedge clk); #1;
    rdy_in[sel] = 1'b0;
    check_val({tag, "/post_valid"}, 64'(vo[sel]), 64'd0);
    check_val({tag, "/post_ready"}, 64'(rdy[sel]), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    for (int s = 0; s < 2; s++) begin
      check_val({tag, "/valid"}, 64'(vo[s]), 64'd0);
      check_val({tag, "/ready"}, 64'(rdy[s]), 64'd1);
      check_val({tag, "/busy"}, 64'(bsy[s]), 64'd0);
      check_val({tag, "/result"}, res_of(s), 64'd0);
    end
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_8000_0000;
      3: return 64'h7FFF_FFFF_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic seen;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; vld = '0; flush = '0; rdy_in = '0;
    op = '0; sg = '0; op_a = '0; op_b = '0; op_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mulhu",   0, 2'b10, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE, 0);
    run_op("mulh",    0, 2'b10, 2'b11, 64'h8000_0000, 64'h8000_0000, 64'd0, 64'h4000_0000, 0);
    run_op("mulhsu",  0, 2'b10, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF, 0);
    run_op("mul_lo",  0, 2'b00, 2'b00, 64'h0001_0003, 64'h0002_0005, 64'd0, 64'h000B_000F, 0);
    run_op("mac",     0, 2'b01, 2'b11, 64'hFFFF_FFFE, 64'h0000_0003, 64'h10, 64'h0000_000A, 0);
    run_op("op11_lo", 0, 2'b11, 2'b00, 64'h0001_0003, 64'h0002_0005, 64'd0, 64'h000B_000F, 0);
    run_op("sg10_hi", 0, 2'b10, 2'b10, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE, 0);
    run_op("bp",      0, 2'b10, 2'b11, 64'h8000_0000, 64'h8000_0000, 64'd0, 64'h4000_0000, 3);

    // Flush in the second CALC cycle: back to IDLE next edge, never a result.
    drive_req(0, 2'b10, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0);
    @(posedge clk); #1;
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    check_val("flush/busy", 64'(bsy[0]), 64'd0);
    check_val("flush/ready", 64'(rdy[0]), 64'd1);
    seen = vo[0];
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | vo[0];
    end
    check_val("flush/no_valid", 64'(seen), 64'd0);

    // flush_i wins over a simultaneous request.
    op = 2'b10; sg = 2'b00; op_a = 64'h1234; op_b = 64'h5678;
    vld[0] = 1'b1; flush[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0; flush[0] = 1'b0;
    check_val("flush_vs_valid/busy", 64'(bsy[0]), 64'd0);
    run_op("after_flush", 0, 2'b00, 2'b00, 64'h0001_0003, 64'h0002_0005, 64'd0, 64'h000B_000F, 0);

    run_op("mulh64", 1, 2'b10, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0,
           64'h4000_0000_0000_0000, 0);

    // Asynchronous reset in the middle of a 64-bit CALC.
    drive_req(1, 2'b10, 2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      int          sel, stall;
      logic [1:0]  op_v, sg_v;
      logic [63:0] a, b, c;
      sel   = $urandom_range(0, 1);
      op_v  = 2'($urandom_range(0, 3));
      sg_v  = 2'($urandom_range(0, 3));
      a     = pick_operand();
      b     = pick_operand();
      c     = pick_operand();
      stall = $urandom_range(0, 2);
      run_op($sformatf("rand%0d", k), sel, op_v, sg_v, a, b, c,
             model((sel == 0) ? 32 : 64, op_v, sg_v, a, b, c), stall);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
